// File: rtl/sample_loader_pkg.sv
// Shared types, constants and parameter-derived helpers for the sample frame loader.
package sample_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Bytes per sample for a given sample width.
  function automatic int calc_bps(input int data_width);
    return data_width / BYTE_W;
  endfunction

  // Width of an index selecting one of n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/strobe_edge_det.sv
// Registered rising-edge detector for the write strobe. A strobe already high
// when reset releases is not treated as an edge; it must drop and rise again.
module strobe_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic edge_pulse
);

  logic strobe_q;
  logic strobe_d;
  logic first_q;
  logic first_d;

  // Next history value and the first-cycle-after-reset mask.
  always_comb begin
    strobe_d = strobe;
    first_d  = 1'b0;
  end

  // History register and first-cycle flag.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_q <= 1'b0;
      first_q  <= 1'b1;
    end else begin
      strobe_q <= strobe_d;
      first_q  <= first_d;
    end
  end

  assign edge_pulse = strobe & ~strobe_q & ~first_q;

endmodule

// File: rtl/sample_frame_loader.sv
// Byte-serial multichannel frame assembler with one frame of double buffering,
// a valid/ready output register, byte readback, overrun/timeout flags and abort.
module sample_frame_loader
  import sample_loader_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   wr_strobe,
  input  logic [7:0]                             wr_data,
  input  logic                                   abort,
  input  logic                                   clear_err,
  input  logic                                   frame_ready,
  output logic                                   frame_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0]           frame_data,
  input  logic [idx_width(NUM_CH)-1:0]           rd_ch,
  input  logic [idx_width(DATA_WIDTH/BYTE_W)-1:0] rd_byte,
  output logic [7:0]                             rd_data,
  output logic                                   busy,
  output logic                                   err_overrun,
  output logic                                   err_timeout
);

  localparam int BPS     = calc_bps(DATA_WIDTH);
  localparam int CH_W    = idx_width(NUM_CH);
  localparam int BY_W    = idx_width(BPS);
  localparam int FRAME_W = NUM_CH * DATA_WIDTH;
  localparam int TO_W    = idx_width(TIMEOUT_CYCLES + 1);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [BY_W-1:0] LAST_BY = BY_W'(BPS - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [BY_W-1:0]      byte_idx_q, byte_idx_d;
  logic [CH_W-1:0]      ch_idx_q, ch_idx_d;
  logic [FRAME_W-1:0]   asm_q, asm_d;
  logic [TO_W-1:0]      idle_cnt_q, idle_cnt_d;
  logic                 frame_valid_q, frame_valid_d;
  logic [FRAME_W-1:0]   frame_data_q, frame_data_d;
  logic                 err_overrun_q, err_overrun_d;
  logic                 err_timeout_q, err_timeout_d;

  logic wr_edge;
  logic out_free;
  logic last_byte;
  int   wr_pos;

  strobe_edge_det u_edge (
    .clk        (clk),
    .rst        (rst),
    .strobe     (wr_strobe),
    .edge_pulse (wr_edge)
  );

  assign out_free  = ~frame_valid_q | frame_ready;
  assign last_byte = (ch_idx_q == LAST_CH) && (byte_idx_q == LAST_BY);

  // Bit offset of the byte slot the next write lands in (MSB byte first).
  always_comb begin
    wr_pos = int'(ch_idx_q) * DATA_WIDTH + (BPS - 1 - int'(byte_idx_q)) * BYTE_W;
  end

  // Assembly, FSM next state, output register and error flag updates.
  // NOTE: every signal gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    logic capture;
    logic overrun_set;
    logic timeout_set;

    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    ch_idx_d      = ch_idx_q;
    asm_d         = asm_q;
    idle_cnt_d    = idle_cnt_q;
    frame_valid_d = frame_valid_q & ~frame_ready;
    frame_data_d  = frame_data_q;
    capture       = 1'b0;
    overrun_set   = 1'b0;
    timeout_set   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (wr_edge) capture = 1'b1;
      end
      FILL: begin
        if (abort) begin
          state_d    = IDLE;
          byte_idx_d = '0;
          ch_idx_d   = '0;
          idle_cnt_d = '0;
        end else if (wr_edge) begin
          capture = 1'b1;
        end else if (TIMEOUT_CYCLES != 0 && idle_cnt_q == TO_LAST) begin
          state_d     = IDLE;
          byte_idx_d  = '0;
          ch_idx_d    = '0;
          idle_cnt_d  = '0;
          timeout_set = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      HOLD: begin
        // Buffer is frozen; writes are lost until the output register frees.
        if (wr_edge) overrun_set = 1'b1;
        if (out_free) begin
          frame_data_d  = asm_q;
          frame_valid_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      asm_d[wr_pos +: BYTE_W] = wr_data;
      idle_cnt_d              = '0;
      if (last_byte) begin
        byte_idx_d = '0;
        ch_idx_d   = '0;
        if (out_free) begin
          frame_data_d  = asm_d;
          frame_valid_d = 1'b1;
          state_d       = IDLE;
        end else begin
          state_d = HOLD;
        end
      end else begin
        state_d = FILL;
        if (byte_idx_q == LAST_BY) begin
          byte_idx_d = '0;
          ch_idx_d   = ch_idx_q + 1'b1;
        end else begin
          byte_idx_d = byte_idx_q + 1'b1;
        end
      end
    end

    // A set event in the same cycle as clear_err leaves the flag set.
    err_overrun_d = (err_overrun_q & ~clear_err) | overrun_set;
    err_timeout_d = (err_timeout_q & ~clear_err) | timeout_set;
  end

  // State, counters, buffers and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      byte_idx_q    <= '0;
      ch_idx_q      <= '0;
      asm_q         <= '0;
      idle_cnt_q    <= '0;
      frame_valid_q <= 1'b0;
      frame_data_q  <= '0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      ch_idx_q      <= ch_idx_d;
      asm_q         <= asm_d;
      idle_cnt_q    <= idle_cnt_d;
      frame_valid_q <= frame_valid_d;
      frame_data_q  <= frame_data_d;
      err_overrun_q <= err_overrun_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Byte readback from the output register; out-of-range selects read as zero.
  always_comb begin
    rd_data = '0;
    if (int'(rd_ch) < NUM_CH && int'(rd_byte) < BPS)
      rd_data = frame_data_q[int'(rd_ch) * DATA_WIDTH + (BPS - 1 - int'(rd_byte)) * BYTE_W +: BYTE_W];
  end

  assign frame_valid = frame_valid_q;
  assign frame_data  = frame_data_q;
  assign busy        = (state_q != IDLE);
  assign err_overrun = err_overrun_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_sample_frame_loader.sv
// Directed testbench for sample_frame_loader with a frame scoreboard.
module tb_sample_frame_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_strobe;
  logic [7:0]  wr_data;
  logic        abort;
  logic        clear_err;
  logic        frame_ready;
  logic        frame_valid;
  logic [63:0] frame_data;
  logic [1:0]  rd_ch;
  logic [0:0]  rd_byte;
  logic [7:0]  rd_data;
  logic        busy;
  logic        err_overrun;
  logic        err_timeout;

  int tests_run = 0;
  int tests_failed = 0;
  logic [63:0] exp_q[$];
  logic fv_prev = 1'b0;
  logic hs_prev = 1'b0;

  sample_frame_loader #(
    .NUM_CH         (4),
    .DATA_WIDTH     (16),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_strobe   (wr_strobe),
    .wr_data     (wr_data),
    .abort       (abort),
    .clear_err   (clear_err),
    .frame_ready (frame_ready),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .rd_ch       (rd_ch),
    .rd_byte     (rd_byte),
    .rd_data     (rd_data),
    .busy        (busy),
    .err_overrun (err_overrun),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One write: strobe high two cycles, low one.
  task automatic write_byte(input logic [7:0] b);
    wr_data   = b;
    wr_strobe = 1'b1;
    tick(2);
    wr_strobe = 1'b0;
    tick(1);
  endtask

  // Send the first n bytes of seq, most significant byte first.
  task automatic write_bytes(input logic [63:0] seq, input int n);
    for (int i = 0; i < n; i++) write_byte(seq[63 - 8*i -: 8]);
  endtask

  // Monitor: compare each newly presented frame against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      fv_prev = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (frame_valid && (!fv_prev || hs_prev)) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_frame: got %h expected none", frame_data);
        end else begin
          check("frame_data", frame_data, exp_q.pop_front());
        end
      end
      fv_prev = frame_valid;
      hs_prev = frame_valid && frame_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_strobe = 1'b1; wr_data = 8'h99; abort = 1'b0;
    clear_err = 1'b0; frame_ready = 1'b0; rd_ch = 2'd0; rd_byte = 1'b0;
    #23;
    check("rst_frame_valid", frame_valid, 0);
    check("rst_frame_data", frame_data, 0);
    check("rst_busy", busy, 0);
    check("rst_errors", {err_overrun, err_timeout}, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    // Strobe high through reset release must not write.
    tick(3);
    check("strobe_high_at_release", busy, 0);
    wr_strobe = 1'b0;
    tick(1);

    // Single frame, latency and readback.
    exp_q.push_back(64'hFFFF_0001_ABCD_1234);
    write_bytes(64'h1234_ABCD_0001_FFFF, 7);
    wr_data = 8'hFF; wr_strobe = 1'b1;
    check("valid_before_last_edge", frame_valid, 0);
    tick(1);
    check("valid_after_last_edge", frame_valid, 1);
    tick(1); wr_strobe = 1'b0; tick(1);
    rd_ch = 2'd1; rd_byte = 1'b0; #1 check("rd_ch1_b0", rd_data, 8'hAB);
    rd_ch = 2'd0; rd_byte = 1'b1; #1 check("rd_ch0_b1", rd_data, 8'h34);
    rd_ch = 2'd3; rd_byte = 1'b0; #1 check("rd_ch3_b0", rd_data, 8'hFF);
    rd_ch = 2'd2; rd_byte = 1'b1; #1 check("rd_ch2_b1", rd_data, 8'h01);
    check("busy_after_frame", busy, 0);
    frame_ready = 1'b1; tick(1); frame_ready = 1'b0;
    check("valid_after_accept", frame_valid, 0);

    // Held strobe with data changing mid-pulse captures one byte.
    frame_ready = 1'b1;
    exp_q.push_back(64'hBBCC_99AA_7788_5566);
    wr_data = 8'h55; wr_strobe = 1'b1; tick(5);
    wr_data = 8'hAA; tick(5);
    wr_strobe = 1'b0; tick(1);
    check("busy_after_held_strobe", busy, 1);
    write_bytes(64'h6677_8899_AABB_CC00, 7);
    tick(1);
    frame_ready = 1'b0;
    tick(1);

    // Backpressure: A in output, B held, 17th byte overruns.
    exp_q.push_back(64'h0708_0506_0304_0102);
    exp_q.push_back(64'h1718_1516_1314_1112);
    write_bytes(64'h0102_0304_0506_0708, 8);
    write_bytes(64'h1112_1314_1516_1718, 8);
    check("hold_busy", busy, 1);
    check("hold_no_overrun_yet", err_overrun, 0);
    write_byte(8'hEE);
    check("overrun_set", err_overrun, 1);
    check("hold_output_stable", frame_data, 64'h0708_0506_0304_0102);
    frame_ready = 1'b1; tick(1); frame_ready = 1'b0;
    check("hold_release_valid", frame_valid, 1);
    check("hold_release_data", frame_data, 64'h1718_1516_1314_1112);
    check("hold_release_idle", busy, 0);
    clear_err = 1'b1; tick(1); clear_err = 1'b0;
    check("overrun_cleared", err_overrun, 0);

    // Last byte of C on the same edge B is accepted.
    exp_q.push_back(64'h2728_2526_2324_2122);
    write_bytes(64'h2122_2324_2526_2728, 7);
    wr_data = 8'h28; wr_strobe = 1'b1; frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
    check("simul_valid", frame_valid, 1);
    check("simul_data", frame_data, 64'h2728_2526_2324_2122);
    check("simul_no_hold", busy, 0);
    tick(1); wr_strobe = 1'b0; tick(1);
    frame_ready = 1'b1; tick(1); frame_ready = 1'b0;

    // Abort beats a simultaneous edge and realigns the next frame.
    write_bytes(64'hD1D2_D300_0000_0000, 3);
    wr_data = 8'hD4; wr_strobe = 1'b1; abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(1); wr_strobe = 1'b0; tick(1);
    check("abort_idle", busy, 0);
    check("abort_no_errors", {err_overrun, err_timeout}, 0);
    frame_ready = 1'b1;
    exp_q.push_back(64'h8788_8586_8384_8182);
    write_bytes(64'h8182_8384_8586_8788, 8);

    // Timeout after 16 idle cycles inside a partial frame.
    write_bytes(64'h3132_3300_0000_0000, 3);
    tick(8);
    check("timeout_not_yet", err_timeout, 0);
    check("timeout_still_busy", busy, 1);
    tick(12);
    check("timeout_set", err_timeout, 1);
    check("timeout_idle", busy, 0);
    exp_q.push_back(64'h4748_4546_4344_4142);
    write_bytes(64'h4142_4344_4546_4748, 8);
    clear_err = 1'b1; tick(1); clear_err = 1'b0;
    check("timeout_cleared", {err_overrun, err_timeout}, 0);
    frame_ready = 1'b0;

    // Asynchronous reset mid-operation.
    exp_q.push_back(64'h7778_7576_7374_7172);
    write_bytes(64'h7172_7374_7576_7778, 8);
    write_bytes(64'h5152_5354_5500_0000, 5);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", frame_valid, 0);
    check("async_rst_data", frame_data, 0);
    check("async_rst_busy", busy, 0);
    tick(2);
    #3 rst = 1'b0;
    tick(1);
    exp_q.push_back(64'h6768_6566_6364_6162);
    write_bytes(64'h6162_6364_6566_6768, 8);
    tick(2);

    check("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sample_frame_loader.md
Name: sample_frame_loader

Overview:
- Byte-serial ingest block for multichannel sample frames. Assembles NUM_CH samples of DATA_WIDTH bits from 8-bit bus writes, MSB byte first, channel 0 first.
- Presents each complete frame through a valid/ready output register, with byte-addressable readback.
- Parametrised successor of the fixed 4-channel, 16-bit loader at the top-level pin interface.
- New behaviour: strobe edge detection, one frame of double buffering, overrun and timeout detection, abort.

Parameters:
- NUM_CH, 4, number of channels per frame (>=1).
- DATA_WIDTH, 16, bits per sample; must be a multiple of 8.
- TIMEOUT_CYCLES, 1024, idle cycles allowed inside a partial frame; 0 disables the timeout.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- wr_strobe  in  1  write strobe; the rising edge qualifies wr_data.
- wr_data  in  8  byte to write.
- abort  in  1  synchronous; discards the partial frame.
- clear_err  in  1  synchronous; clears the sticky error flags.
- frame_ready  in  1  downstream accepts the frame.
- frame_valid  out  1  output register holds a frame.
- frame_data  out  NUM_CH*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- rd_ch  in  $clog2(NUM_CH) (min 1)  readback channel select.
- rd_byte  in  $clog2(DATA_WIDTH/8) (min 1)  readback byte select; 0 = MSB.
- rd_data  out  8  combinational byte of frame_data selected by rd_ch/rd_byte.
- busy  out  1  partial frame in progress, or assembly buffer held.
- err_overrun  out  1  sticky.
- err_timeout  out  1  sticky.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0; frame_data 0.
  - Counters 0; state IDLE; strobe history register 0.
- Strobe edge:
  - wr_edge = wr_strobe & ~strobe_q; strobe_q registers wr_strobe every cycle.
  - A strobe held high for any number of cycles produces exactly one write.
  - A strobe high at reset release counts as no edge until it goes low and high again.
- Assembly:
  - BPS = DATA_WIDTH/8.
  - Counters byte_idx (0..BPS-1) and ch_idx (0..NUM_CH-1).
  - On wr_edge, wr_data is written into the assembly buffer for channel ch_idx at byte position BPS-1-byte_idx (MSB first). The counters then advance and wrap.
  - Out-of-range rd_ch or rd_byte returns rd_data = 0.
- States:
  - IDLE: no bytes held. wr_edge → capture byte, go to FILL (or complete immediately if NUM_CH*BPS = 1).
  - FILL: wr_edge captures the next byte. On the edge that captures the last byte (ch_idx = NUM_CH-1, byte_idx = BPS-1), the frame is complete:
    - If the output register is free this cycle (frame_valid=0, or frame_ready=1): load it on the same edge, so frame_valid = 1 the cycle after the last-byte edge; go to IDLE.
    - Otherwise go to HOLD.
  - HOLD: the assembly buffer is frozen. When the output register frees (frame_valid & frame_ready, or frame_valid=0), load and go to IDLE on that edge. Any wr_edge in HOLD is dropped and sets err_overrun.
- Output handshake:
  - frame_valid clears on frame_valid & frame_ready unless a new frame loads on the same edge; in that case it stays 1 with the new data.
  - frame_data is stable while frame_valid=1 and frame_ready=0.
- Timeout:
  - An idle counter runs only in FILL and resets on each wr_edge.
  - When it reaches TIMEOUT_CYCLES: discard the partial frame, zero the counters, go to IDLE, set err_timeout.
  - No timeout in IDLE or HOLD.
- Abort:
  - In FILL, zeroes the counters and returns to IDLE.
  - Ignored in HOLD and IDLE.
  - Never affects the output register.
  - Abort wins over a simultaneous wr_edge (that byte is dropped, no error flag).
- Error flags:
  - Sticky until clear_err.
  - A set event in the same cycle as clear_err wins (flag = 1).
- busy = (state != IDLE).

Decomposition:
- Package sample_loader_pkg holds:
  - the state enum (IDLE, FILL, HOLD);
  - the BYTE_W=8 constant;
  - functions returning BPS and the index widths from the parameters.
- One natural sub-module, strobe_edge_det: registered rising-edge detector producing wr_edge.
- Assembly, FSM and output register stay in the top.

Test Plan:
- Single frame, default parameters: write bytes 12,34,AB,CD,00,01,FF,FF (2 cycles high, 1 low each), frame_ready=0.
  - frame_valid rises 1 cycle after the 8th edge.
  - frame_data = 0xFFFF_0001_ABCD_1234.
  - rd_ch=1, rd_byte=0 → rd_data = 0xAB.
- Strobe held high 10 cycles with wr_data changing 0x55→0xAA mid-pulse → exactly one byte captured (0x55); byte_idx advances by 1 only.
- Backpressure: frame_ready=0, complete frame A, then frame B (8 more bytes), then a 17th edge.
  - State HOLD, err_overrun=1, the extra byte dropped.
  - Raise frame_ready for 1 cycle → frame_data = B next cycle, frame_valid stays 1.
- Simultaneous events: last byte of frame B on the same edge that A is accepted (frame_ready=1) → B loads without entering HOLD, frame_valid continuously 1.
- Timeout, TIMEOUT_CYCLES=16: write 3 bytes, idle 16 cycles → err_timeout=1, busy=0. The next 8 bytes form a correctly aligned frame. clear_err → flags 0.
- Reset mid-operation: assert rst asynchronously (between clock edges) after 5 bytes with frame_valid=1 → all outputs 0 immediately; post-reset frame assembles from byte 0.
